// File: rtl/trap_arbiter.sv
// Trap arbiter: picks between a commit-stage exception and an eligible interrupt, holds the trap
// toward the CSR unit until accepted, then flushes until the pipeline drains. Option: TRAP_ARBITER_LCOFI_EN.
module trap_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid,
    output logic            exc_ready,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [15:0]     mip,
    input  logic [15:0]     mie,
    input  logic            mstatus_mie,
    input  logic [1:0]      priv,
    input  logic            irq_boundary,
    input  logic [XLEN-1:0] irq_pc,
    output logic            trap_valid,
    input  logic            trap_ready,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_tval,
    output logic            flush,
    input  logic            pipe_empty
);

    typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            trap_valid_q, trap_valid_d;
    logic            flush_q, flush_d;

    logic        irq_gie;
    logic [15:0] irq_elig;
    logic        irq_any;
    logic [4:0]  irq_code;

    assign irq_gie  = (priv != 2'd3) || mstatus_mie;
    assign irq_elig = irq_gie ? (mip & mie) : 16'h0000;

    // Only the standard M/S sources (and optionally COI) take part in arbitration.
    logic unused_irq;
`ifdef TRAP_ARBITER_LCOFI_EN
    assign unused_irq = ^{irq_elig[15:14], irq_elig[12], irq_elig[10], irq_elig[8],
                          irq_elig[6], irq_elig[4], irq_elig[2], irq_elig[0]};
`else
    assign unused_irq = ^{irq_elig[15:12], irq_elig[10], irq_elig[8],
                          irq_elig[6], irq_elig[4], irq_elig[2], irq_elig[0]};
`endif

    always_comb begin
        irq_any  = 1'b1;
        irq_code = 5'd0;
        if (irq_elig[11]) begin
            irq_code = 5'd11;
        end else if (irq_elig[3]) begin
            irq_code = 5'd3;
        end else if (irq_elig[7]) begin
            irq_code = 5'd7;
        end else if (irq_elig[9]) begin
            irq_code = 5'd9;
        end else if (irq_elig[1]) begin
            irq_code = 5'd1;
        end else if (irq_elig[5]) begin
            irq_code = 5'd5;
`ifdef TRAP_ARBITER_LCOFI_EN
        end else if (irq_elig[13]) begin
            irq_code = 5'd13;
`endif
        end else begin
            irq_any = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        unique case (state_q)
            StIdle: begin
                // Exceptions win; a coincident interrupt is re-evaluated back in idle.
                if (exc_valid) begin
                    cause_d = {{(XLEN-5){1'b0}}, exc_code};
                    epc_d   = exc_pc;
                    tval_d  = exc_tval;
                    state_d = StReq;
                end else if (irq_boundary && irq_any) begin
                    cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
                    epc_d   = irq_pc;
                    tval_d  = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (trap_ready) state_d = StDrain;
            end
            StDrain: begin
                if (pipe_empty) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        trap_valid_d = (state_d == StReq);
        flush_d      = (state_d == StDrain);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cause_q      <= '0;
            epc_q        <= '0;
            tval_q       <= '0;
            trap_valid_q <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            epc_q        <= epc_d;
            tval_q       <= tval_d;
            trap_valid_q <= trap_valid_d;
            flush_q      <= flush_d;
        end
    end

    assign exc_ready  = (state_q == StIdle);
    assign trap_valid = trap_valid_q;
    assign flush      = flush_q;
    assign trap_cause = cause_q;
    assign trap_epc   = epc_q;
    assign trap_tval  = tval_q;

endmodule

// File: tb/tb_trap_arbiter.sv
// Self-checking bench for trap_arbiter: scenario tasks plus a scoreboard of expected traps
// that is retired at every trap handshake.
module tb_trap_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic        exc_ready;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic [15:0] mip;
    logic [15:0] mie;
    logic        mstatus_mie;
    logic [1:0]  priv;
    logic        irq_boundary;
    logic [31:0] irq_pc;
    logic        trap_valid;
    logic        trap_ready;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        flush;
    logic        pipe_empty;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   checks = 0;
    int   errors = 0;

    trap_arbiter #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exc_valid    (exc_valid),
        .exc_ready    (exc_ready),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .exc_tval     (exc_tval),
        .mip          (mip),
        .mie          (mie),
        .mstatus_mie  (mstatus_mie),
        .priv         (priv),
        .irq_boundary (irq_boundary),
        .irq_pc       (irq_pc),
        .trap_valid   (trap_valid),
        .trap_ready   (trap_ready),
        .trap_cause   (trap_cause),
        .trap_epc     (trap_epc),
        .trap_tval    (trap_tval),
        .flush        (flush),
        .pipe_empty   (pipe_empty)
    );

    always #5 clk = ~clk;

    // Retire the scoreboard at every accepted trap (sampled mid-cycle, before the edge).
    always @(negedge clk) begin
        if (trap_valid === 1'b1 && trap_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected trap cause=%h epc=%h tval=%h",
                         trap_cause, trap_epc, trap_tval);
            end else begin
                mon_exp = sb.pop_front();
                if ({trap_cause, trap_epc, trap_tval} !== {mon_exp.cause, mon_exp.epc, mon_exp.tval}) begin
                    errors++;
                    $display("FAIL scoreboard: got cause=%h epc=%h tval=%h, want cause=%h epc=%h tval=%h",
                             trap_cause, trap_epc, trap_tval, mon_exp.cause, mon_exp.epc, mon_exp.tval);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] cause, input logic [31:0] epc,
                            input logic [31:0] tval);
        exp_t e;
        e.cause = cause;
        e.epc   = epc;
        e.tval  = tval;
        sb.push_back(e);
    endtask

    task automatic finish_trap();
        trap_ready = 1'b1;
        tick();
        trap_ready = 1'b0;
        pipe_empty = 1'b1;
        tick();
        pipe_empty = 1'b0;
    endtask

    task automatic clear_irq();
        irq_boundary = 1'b0;
        mip          = 16'h0000;
        mie          = 16'h0000;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (trap_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_tval = '0;
        mip = '0; mie = '0; mstatus_mie = 1'b0; priv = 2'd3; irq_boundary = 1'b0;
        irq_pc = '0; trap_ready = 1'b0; pipe_empty = 1'b0;
        tick();
        tick();
        checks++;
        if (exc_ready !== 1'b1) begin
            errors++; $display("FAIL reset exc_ready: got %b want 1", exc_ready);
        end
        checks++;
        if ({trap_valid, flush} !== 2'b00) begin
            errors++; $display("FAIL reset valid/flush: got %b%b want 00", trap_valid, flush);
        end
        checks++;
        if ({trap_cause, trap_epc, trap_tval} !== 96'h0) begin
            errors++;
            $display("FAIL reset payload: got %h %h %h want zeros", trap_cause, trap_epc, trap_tval);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exception();
        exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
        push_exp(32'h0000_0002, 32'h100, 32'hDEAD);
        tick();
        exc_valid = 1'b0;
        checks++;
        if ({trap_valid, exc_ready} !== 2'b10) begin
            errors++; $display("FAIL exc latency: got valid=%b ready=%b want 1 0", trap_valid, exc_ready);
        end
        checks++;
        if (trap_cause !== 32'h0000_0002) begin
            errors++; $display("FAIL exc cause: got %h want 00000002", trap_cause);
        end
        trap_ready = 1'b1;
        tick();
        trap_ready = 1'b0;
        checks++;
        if ({flush, trap_valid, exc_ready} !== 3'b100) begin
            errors++; $display("FAIL exc drain: got flush=%b valid=%b ready=%b want 1 0 0",
                               flush, trap_valid, exc_ready);
        end
        pipe_empty = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++; $display("FAIL exc flush at pipe_empty: got %b want 1", flush);
        end
        tick();
        pipe_empty = 1'b0;
        checks++;
        if ({exc_ready, flush} !== 2'b10) begin
            errors++; $display("FAIL exc return idle: got ready=%b flush=%b want 1 0", exc_ready, flush);
        end
    endtask

    task automatic test_irq_priority();
        logic [15:0] pr_mip [8];
        logic [15:0] pr_mie [8];
        logic [4:0]  pr_code [8];
        pr_mip  = '{16'h0888, 16'h0AAA, 16'h00AA, 16'h02A2, 16'h0222, 16'h0022, 16'h0FFF, 16'h4020};
        pr_mie  = '{16'h0888, 16'h0AAA, 16'h00AA, 16'h02A2, 16'h0222, 16'h0022, 16'h0020, 16'h4020};
        pr_code = '{5'd11, 5'd11, 5'd3, 5'd7, 5'd9, 5'd1, 5'd5, 5'd5};
        for (int i = 0; i < 8; i++) begin
            // Odd entries rely on a lower privilege instead of mstatus.MIE.
            priv         = (i % 2 == 1) ? 2'd0 : 2'd3;
            mstatus_mie  = (i % 2 == 1) ? 1'b0 : 1'b1;
            mip          = pr_mip[i];
            mie          = pr_mie[i];
            irq_pc       = 32'h2000 + 32'(i * 4);
            irq_boundary = 1'b1;
            push_exp({27'h400_0000, pr_code[i]}, irq_pc, 32'h0);
            tick();
            clear_irq();
            checks++;
            if (trap_valid !== 1'b1) begin
                errors++; $display("FAIL irq prio %0d: got trap_valid=%b want 1", i, trap_valid);
            end
            finish_trap();
        end
        priv = 2'd3;
        mstatus_mie = 1'b0;
    endtask

    task automatic test_irq_masking();
        priv = 2'd3; mstatus_mie = 1'b0; mip = 16'h0888; mie = 16'h0888; irq_boundary = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({trap_valid, exc_ready} !== 2'b01) begin
            errors++; $display("FAIL mask mstatus_mie: got valid=%b ready=%b want 0 1", trap_valid, exc_ready);
        end
        mstatus_mie = 1'b1; irq_boundary = 1'b0;
        tick(); tick();
        checks++;
        if (trap_valid !== 1'b0) begin
            errors++; $display("FAIL mask no boundary: got trap_valid=%b want 0", trap_valid);
        end
        irq_boundary = 1'b1; mie = 16'h0000;
        tick(); tick();
        checks++;
        if (trap_valid !== 1'b0) begin
            errors++; $display("FAIL mask mie zero: got trap_valid=%b want 0", trap_valid);
        end
        mip = 16'hC015; mie = 16'hC015;
        tick(); tick();
        checks++;
        if (trap_valid !== 1'b0) begin
            errors++; $display("FAIL mask ignored bits: got trap_valid=%b want 0", trap_valid);
        end
        mip = 16'h0888; mie = 16'h0888; mstatus_mie = 1'b0; priv = 2'd0; irq_pc = 32'h2400;
        push_exp(32'h8000_000B, 32'h2400, 32'h0);
        tick();
        clear_irq();
        checks++;
        if (trap_valid !== 1'b1) begin
            errors++; $display("FAIL mask priv 0: got trap_valid=%b want 1", trap_valid);
        end
        finish_trap();
        priv = 2'd3;
    endtask

    task automatic test_collision();
        bit ok;
        priv = 2'd3; mstatus_mie = 1'b1; mip = 16'h0080; mie = 16'h0080;
        irq_boundary = 1'b1; irq_pc = 32'h3000;
        exc_valid = 1'b1; exc_code = 5'd3; exc_pc = 32'h400; exc_tval = 32'h55;
        push_exp(32'h0000_0003, 32'h400, 32'h55);
        push_exp(32'h8000_0007, 32'h3000, 32'h0);
        tick();
        exc_valid = 1'b0;
        checks++;
        if (trap_cause !== 32'h0000_0003) begin
            errors++; $display("FAIL collision first: got cause=%h want 00000003", trap_cause);
        end
        finish_trap();
        wait_valid(4, ok);
        clear_irq();
        checks++;
        if (!ok) begin
            errors++; $display("FAIL collision follow-up: got no trap_valid, want MTI trap");
        end
        finish_trap();
    endtask

    task automatic test_back_pressure();
        exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h500; exc_tval = 32'hBEEF;
        push_exp(32'h0000_0005, 32'h500, 32'hBEEF);
        tick();
        exc_valid = 1'b0;
        mstatus_mie = 1'b1; mie = 16'hFFFF; irq_boundary = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mip = 16'($urandom) | 16'h0800;
            tick();
            checks++;
            if ({trap_valid, trap_cause, trap_epc, trap_tval} !==
                {1'b1, 32'h0000_0005, 32'h500, 32'hBEEF}) begin
                errors++;
                $display("FAIL stall %0d: got valid=%b cause=%h epc=%h tval=%h want 1 5 500 beef",
                         i, trap_valid, trap_cause, trap_epc, trap_tval);
            end
        end
        clear_irq();
        trap_ready = 1'b1;
        tick();
        trap_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({flush, exc_ready} !== 2'b10) begin
                errors++; $display("FAIL drain hold %0d: got flush=%b ready=%b want 1 0", i, flush, exc_ready);
            end
            tick();
        end
        pipe_empty = 1'b1;
        tick();
        pipe_empty = 1'b0;
        checks++;
        if ({exc_ready, flush} !== 2'b10) begin
            errors++; $display("FAIL drain exit: got ready=%b flush=%b want 1 0", exc_ready, flush);
        end
    endtask

    task automatic test_lcofi();
        priv = 2'd3; mstatus_mie = 1'b1; mip = 16'h2000; mie = 16'h2000;
        irq_pc = 32'h4000; irq_boundary = 1'b1;
`ifdef TRAP_ARBITER_LCOFI_EN
        push_exp(32'h8000_000D, 32'h4000, 32'h0);
        tick();
        clear_irq();
        checks++;
        if (trap_valid !== 1'b1) begin
            errors++; $display("FAIL lcofi taken: got trap_valid=%b want 1", trap_valid);
        end
        finish_trap();
        mip = 16'h2020; mie = 16'h2020; irq_boundary = 1'b1;
        push_exp(32'h8000_0005, 32'h4000, 32'h0);
        tick();
        clear_irq();
        finish_trap();
`else
        tick(); tick(); tick();
        checks++;
        if (trap_valid !== 1'b0) begin
            errors++; $display("FAIL lcofi ignored: got trap_valid=%b want 0", trap_valid);
        end
        clear_irq();
`endif
    endtask

    task automatic test_reset_abandon();
        exc_valid = 1'b1; exc_code = 5'd7; exc_pc = 32'h700; exc_tval = 32'h77;
        tick();
        exc_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({trap_valid, exc_ready, trap_cause} !== {2'b01, 32'h0}) begin
            errors++; $display("FAIL reset in req: got valid=%b ready=%b cause=%h want 0 1 0",
                               trap_valid, exc_ready, trap_cause);
        end
        exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h800; exc_tval = 32'h88;
        push_exp(32'h0000_0008, 32'h800, 32'h88);
        tick();
        exc_valid = 1'b0;
        trap_ready = 1'b1;
        tick();
        trap_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({flush, exc_ready, trap_epc} !== {2'b01, 32'h0}) begin
            errors++; $display("FAIL reset in drain: got flush=%b ready=%b epc=%h want 0 1 0",
                               flush, exc_ready, trap_epc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_irq_priority();
        test_irq_masking();
        test_collision();
        test_back_pressure();
        test_lcofi();
        test_reset_abandon();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard drain: got %0d pending traps want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
